noc_vc_fifo: RTL and testbench

Multi-virtual-channel input buffer for the 8x8 mesh router ports. It holds NUM_VC independent FIFO lanes behind one shared write port and one shared read port. The read side is first-word-fall-through (zero read latency). Each pop returns a registered credit to the upstream router. It replaces the single-lane, RAM-backed buffer on router inputs so head-of-line blocking is confined to one VC.

---
 rtl/noc_fifo_pkg.sv | 28 ++
 rtl/noc_vc_fifo_lane.sv | 77 +++++++
 rtl/noc_vc_fifo.sv | 139 +++++++++++++
 tb/tb_noc_vc_fifo.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_fifo_pkg.sv
// Shared types and elaboration helpers for the NoC virtual-channel input buffer.
package noc_fifo_pkg;

    // Widest VC select field the credit payload can carry.
    localparam int unsigned CREDIT_VC_W = 8;

    // Width of a VC select field: clog2 of the VC count, never below one bit.
    function automatic int unsigned vc_id_w(input int unsigned num_vc);
        return (num_vc <= 32'd1) ? 32'd1 : 32'($clog2(num_vc));
    endfunction

    // Per-lane occupancy counter width; one extra bit so "full" is representable.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return 32'($clog2(depth)) + 32'd1;
    endfunction

    // True when n is a non-zero power of two.
    function automatic bit is_pow2(input int unsigned n);
        return (n != 32'd0) && ((n & (n - 32'd1)) == 32'd0);
    endfunction

    // Credit returned upstream after a pop.
    typedef struct packed {
        logic                   valid;
        logic [CREDIT_VC_W-1:0] vc;
    } credit_t;

endpackage

// File: rtl/noc_vc_fifo_lane.sv
// Single-VC first-word-fall-through FIFO built on a flop array.
// Head data is read combinationally from the array; a push into an empty
// lane becomes visible one cycle later (no write-to-read bypass).
module noc_vc_fifo_lane
    import noc_fifo_pkg::*;
#(
    parameter int unsigned  WIDTH = 8,
    parameter int unsigned  DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_c,
    output logic [CNT_W-1:0] count_o,
    output logic             full_c,
    output logic             empty_c
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign head_c  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // The lane protects itself against push-when-full and pop-when-empty.
    assign do_push = push_i && !full_c;
    assign do_pop  = pop_i && !empty_c;

    // Next pointer/count; pointers wrap naturally at the power-of-2 depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the lane is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/noc_vc_fifo.sv
// Multi-VC router input buffer: NUM_VC independent FWFT lanes behind one
// shared write port and one shared read port, with a registered credit per pop
// and a sticky overflow flag.
// Build option: define NOC_VCFIFO_OCC_EN to expose the per-VC registered
// counts on o_occupancy (VC0 in the LSBs).
module noc_vc_fifo
    import noc_fifo_pkg::*;
#(
    parameter int unsigned  FIFO_WIDTH = 8,
    parameter int unsigned  FIFO_DEPTH = 8,
    parameter int unsigned  NUM_VC     = 2,
    localparam int unsigned VC_W       = vc_id_w(NUM_VC),
    localparam int unsigned CNT_W      = cnt_w(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr_valid,
    input  logic [VC_W-1:0]       i_wr_vc,
    input  logic [FIFO_WIDTH-1:0] i_wr_data,
    output logic [NUM_VC-1:0]     o_wr_ready,
    input  logic [VC_W-1:0]       i_rd_vc,
    input  logic                  i_rd_ready,
    output logic [FIFO_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic [NUM_VC-1:0]     o_vc_nonempty,
    output logic                  o_credit_valid,
    output logic [VC_W-1:0]       o_credit_vc,
    output logic                  o_err_overflow
`ifdef NOC_VCFIFO_OCC_EN
    ,
    output logic [NUM_VC*CNT_W-1:0] o_occupancy
`endif
);

    if (!is_pow2(FIFO_DEPTH) || (FIFO_DEPTH < 32'd2)) begin : g_depth_chk
        $error("noc_vc_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    if ((NUM_VC == 32'd0) || (VC_W > CREDIT_VC_W)) begin : g_vc_chk
        $error("noc_vc_fifo: NUM_VC must be >= 1 and fit the credit VC field");
    end

    logic [NUM_VC-1:0]       push_c;
    logic [NUM_VC-1:0]       pop_c;
    logic [NUM_VC-1:0]       full_c;
    logic [NUM_VC-1:0]       empty_c;
    logic [FIFO_WIDTH-1:0]   head_c [NUM_VC];
    logic [NUM_VC*CNT_W-1:0] occ_c;
    logic                    wr_accept_c;
    logic                    rd_fire_c;
    logic                    rd_nonempty_c;
    credit_t                 credit_q, credit_d;
    logic                    ovf_q, ovf_d;
    logic                    credit_hi_unused;

    // One FIFO lane per virtual channel.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_lane
        noc_vc_fifo_lane #(
            .WIDTH (FIFO_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .push_i  (push_c[v]),
            .wdata_i (i_wr_data),
            .pop_i   (pop_c[v]),
            .head_c  (head_c[v]),
            .count_o (occ_c[v*CNT_W +: CNT_W]),
            .full_c  (full_c[v]),
            .empty_c (empty_c[v])
        );
    end

    // Write/read VC decode; an out-of-range VC matches no lane and is dropped.
    always_comb begin
        push_c = '0;
        pop_c  = '0;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            if (i_wr_valid && (i_wr_vc == VC_W'(v)) && !full_c[v]) begin
                push_c[v] = 1'b1;
            end
            if (i_rd_ready && (i_rd_vc == VC_W'(v)) && !empty_c[v]) begin
                pop_c[v] = 1'b1;
            end
        end
    end

    // Read mux: head of the selected lane, valid in the same cycle.
    always_comb begin
        o_rd_data     = '0;
        rd_nonempty_c = 1'b0;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            if (i_rd_vc == VC_W'(v)) begin
                o_rd_data     = head_c[v];
                rd_nonempty_c = !empty_c[v];
            end
        end
    end

    assign wr_accept_c   = |push_c;
    assign rd_fire_c     = |pop_c;
    assign o_rd_valid    = rd_nonempty_c;
    assign o_wr_ready    = ~full_c;
    assign o_vc_nonempty = ~empty_c;

    // Credit and overflow next state; credit VC holds its last value when idle.
    always_comb begin
        credit_d       = credit_q;
        credit_d.valid = rd_fire_c;
        if (rd_fire_c) begin
            credit_d.vc = CREDIT_VC_W'(i_rd_vc);
        end
        ovf_d = ovf_q | (i_wr_valid && !wr_accept_c);
    end

    // Credit and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_credit_valid   = credit_q.valid;
    assign o_credit_vc      = credit_q.vc[VC_W-1:0];
    assign o_err_overflow   = ovf_q;
    assign credit_hi_unused = ^(credit_q.vc >> VC_W);

`ifdef NOC_VCFIFO_OCC_EN
    assign o_occupancy = occ_c;
`else
    logic occ_unused;
    assign occ_unused = ^occ_c;
`endif

endmodule

// File: tb/tb_noc_vc_fifo.sv
// Self-checking bench for noc_vc_fifo with a queue-based reference model.
module tb_noc_vc_fifo;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int NV = 2;
    localparam int VW = 1;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_wr_valid;
    logic [VW-1:0] i_wr_vc;
    logic [W-1:0]  i_wr_data;
    logic [NV-1:0] o_wr_ready;
    logic [VW-1:0] i_rd_vc;
    logic          i_rd_ready;
    logic [W-1:0]  o_rd_data;
    logic          o_rd_valid;
    logic [NV-1:0] o_vc_nonempty;
    logic          o_credit_valid;
    logic [VW-1:0] o_credit_vc;
    logic          o_err_overflow;
`ifdef NOC_VCFIFO_OCC_EN
    logic [NV*CW-1:0] o_occupancy;
`endif

    always #5 clk = ~clk;

    noc_vc_fifo #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (D),
        .NUM_VC     (NV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_wr_valid     (i_wr_valid),
        .i_wr_vc        (i_wr_vc),
        .i_wr_data      (i_wr_data),
        .o_wr_ready     (o_wr_ready),
        .i_rd_vc        (i_rd_vc),
        .i_rd_ready     (i_rd_ready),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .o_vc_nonempty  (o_vc_nonempty),
        .o_credit_valid (o_credit_valid),
        .o_credit_vc    (o_credit_vc),
        .o_err_overflow (o_err_overflow)
`ifdef NOC_VCFIFO_OCC_EN
        ,
        .o_occupancy    (o_occupancy)
`endif
    );

    // Reference model: one queue per VC plus expected credit/overflow state.
    logic [W-1:0]  mq [NV][$];
    logic          exp_cv;
    logic [VW-1:0] exp_cvc;
    logic          exp_ovf;
    int            errors = 0;
    int            checks = 0;

    function automatic logic [NV-1:0] exp_ready();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = (mq[v].size() < D);
        return r;
    endfunction

    function automatic logic [NV-1:0] exp_nonempty();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = (mq[v].size() > 0);
        return r;
    endfunction

    function automatic logic [NV*CW-1:0] exp_occ();
        logic [NV*CW-1:0] r;
        for (int v = 0; v < NV; v++) r[v*CW +: CW] = CW'(mq[v].size());
        return r;
    endfunction

    // Apply inputs just after a falling edge and let them settle.
    task automatic drive(input logic wv, input logic [VW-1:0] wvc, input logic [W-1:0] wd,
                         input logic [VW-1:0] rvc, input logic rr);
        i_wr_valid = wv;
        i_wr_vc    = wvc;
        i_wr_data  = wd;
        i_rd_vc    = rvc;
        i_rd_ready = rr;
        #1;
    endtask

    // Advance one clock and update the model from the inputs applied.
    task automatic tick();
        bit acc, pop;
        int wi, ri;
        wi  = int'(i_wr_vc);
        ri  = int'(i_rd_vc);
        acc = i_wr_valid && (mq[wi].size() < D);
        pop = i_rd_ready && (mq[ri].size() > 0);
        @(posedge clk);
        if (reset) begin
            for (int v = 0; v < NV; v++) mq[v].delete();
            exp_cv  = 1'b0;
            exp_cvc = '0;
            exp_ovf = 1'b0;
        end else begin
            if (pop) void'(mq[ri].pop_front());
            if (acc) mq[wi].push_back(i_wr_data);
            exp_cv = pop;
            if (pop) exp_cvc = VW'(ri);
            if (i_wr_valid && !acc) exp_ovf = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 0, 0, 0, 0);
        checks++; if (o_wr_ready !== 2'b11) begin errors++; $display("FAIL reset_wr_ready got=%b exp=11", o_wr_ready); end
        checks++; if (o_vc_nonempty !== 2'b00) begin errors++; $display("FAIL reset_nonempty got=%b exp=00", o_vc_nonempty); end
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", o_rd_valid); end
        checks++; if (o_credit_valid !== 1'b0) begin errors++; $display("FAIL reset_credit_valid got=%b exp=0", o_credit_valid); end
        checks++; if (o_credit_vc !== 1'b0) begin errors++; $display("FAIL reset_credit_vc got=%b exp=0", o_credit_vc); end
        checks++; if (o_err_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", o_err_overflow); end
`ifdef NOC_VCFIFO_OCC_EN
        checks++; if (o_occupancy !== '0) begin errors++; $display("FAIL reset_occupancy got=%h exp=0", o_occupancy); end
`endif
    endtask

    task automatic test_fill_drain();
        logic [W-1:0] expd;
        do_reset();
        for (int i = 0; i < D; i++) begin
            drive(1, 1, W'(i + 1), 1, 0);
            checks++; if (o_wr_ready !== exp_ready()) begin errors++; $display("FAIL fill_wr_ready i=%0d got=%b exp=%b", i, o_wr_ready, exp_ready()); end
            tick();
        end
        drive(0, 0, 0, 1, 0);
        checks++; if (o_wr_ready !== 2'b01) begin errors++; $display("FAIL fill_full_ready got=%b exp=01", o_wr_ready); end
        checks++; if (o_vc_nonempty !== 2'b10) begin errors++; $display("FAIL fill_nonempty got=%b exp=10", o_vc_nonempty); end
        for (int i = 0; i < D; i++) begin
            drive(0, 0, 0, 1, 1);
            expd = W'(i + 1);
            checks++; if (o_rd_valid !== 1'b1) begin errors++; $display("FAIL drain_valid i=%0d got=%b exp=1", i, o_rd_valid); end
            checks++; if (o_rd_data !== expd) begin errors++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, o_rd_data, expd); end
            checks++; if (o_credit_valid !== exp_cv || (exp_cv && o_credit_vc !== 1'b1)) begin errors++; $display("FAIL drain_credit i=%0d got=%b/%b exp=%b/1", i, o_credit_valid, o_credit_vc, exp_cv); end
            tick();
        end
        drive(0, 0, 0, 1, 0);
        checks++; if (o_credit_valid !== 1'b1 || o_credit_vc !== 1'b1) begin errors++; $display("FAIL drain_last_credit got=%b/%b exp=1/1", o_credit_valid, o_credit_vc); end
        checks++; if (o_vc_nonempty[1] !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", o_vc_nonempty[1]); end
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL drain_rd_valid got=%b exp=0", o_rd_valid); end
        tick();
        drive(0, 0, 0, 1, 0);
        checks++; if (o_credit_valid !== 1'b0) begin errors++; $display("FAIL drain_credit_idle got=%b exp=0", o_credit_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < D; i++) begin
            drive(1, 0, W'($urandom_range(0, 127)), 0, 0);
            tick();
        end
        drive(1, 0, 8'hAA, 0, 0);
        checks++; if (o_wr_ready[0] !== 1'b0) begin errors++; $display("FAIL ovf_ready got=%b exp=0", o_wr_ready[0]); end
        checks++; if (o_err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", o_err_overflow); end
        tick();
        drive(0, 0, 0, 0, 0);
        checks++; if (o_err_overflow !== 1'b1 || exp_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", o_err_overflow); end
        for (int i = 0; i < D; i++) begin
            drive(0, 0, 0, 0, 1);
            checks++; if (o_rd_data !== mq[0][0] || o_rd_data === 8'hAA) begin errors++; $display("FAIL ovf_drain i=%0d got=%h exp=%h", i, o_rd_data, mq[0][0]); end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", o_rd_valid); end
        checks++; if (o_err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", o_err_overflow); end
        do_reset();
        drive(0, 0, 0, 0, 0);
        checks++; if (o_err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got=%b exp=0", o_err_overflow); end
    endtask

    task automatic test_simul_push_pop();
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, W'($urandom_range(0, 63)), 0, 0);
            tick();
        end
        drive(1, 0, 8'h55, 0, 1);
        checks++; if (o_rd_data !== mq[0][0]) begin errors++; $display("FAIL simul_head got=%h exp=%h", o_rd_data, mq[0][0]); end
        tick();
        drive(0, 0, 0, 0, 0);
        checks++; if (mq[0].size() != 3 || o_vc_nonempty !== 2'b01) begin errors++; $display("FAIL simul_count nonempty got=%b exp=01", o_vc_nonempty); end
`ifdef NOC_VCFIFO_OCC_EN
        checks++; if (o_occupancy[3:0] !== 4'd3) begin errors++; $display("FAIL simul_occ got=%0d exp=3", o_occupancy[3:0]); end
`endif
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1);
            checks++; if (o_rd_data !== mq[0][0] || (i == 2 && o_rd_data !== 8'h55)) begin errors++; $display("FAIL simul_drain i=%0d got=%h exp=%h", i, o_rd_data, mq[0][0]); end
            tick();
        end
        for (int i = 0; i < D; i++) begin
            drive(1, 0, W'($urandom_range(0, 63)), 0, 0);
            tick();
        end
        drive(1, 0, 8'h55, 0, 1);
        checks++; if (o_wr_ready[0] !== 1'b0) begin errors++; $display("FAIL simul_full_ready got=%b exp=0", o_wr_ready[0]); end
        tick();
        drive(0, 0, 0, 0, 0);
        checks++; if (o_err_overflow !== 1'b1) begin errors++; $display("FAIL simul_full_ovf got=%b exp=1", o_err_overflow); end
`ifdef NOC_VCFIFO_OCC_EN
        checks++; if (o_occupancy[3:0] !== 4'd7) begin errors++; $display("FAIL simul_full_occ got=%0d exp=7", o_occupancy[3:0]); end
`endif
        n = 0;
        for (int k = 0; k < 2 * D; k++) begin
            drive(0, 0, 0, 0, 1);
            if (o_rd_valid !== 1'b1) break;
            checks++; if (o_rd_data !== mq[0][0] || o_rd_data === 8'h55) begin errors++; $display("FAIL simul_full_drain k=%0d got=%h exp=%h", k, o_rd_data, mq[0][0]); end
            n++;
            tick();
        end
        checks++; if (n != 7) begin errors++; $display("FAIL simul_full_count got=%0d exp=7", n); end
    endtask

    task automatic test_vc_independence();
        logic [W-1:0] head0;
        do_reset();
        for (int i = 0; i < D; i++) begin
            drive(1, 0, W'($urandom_range(0, 255)), 0, 0);
            tick();
        end
        head0 = mq[0][0];
        drive(1, 1, 8'h77, 1, 0);
        tick();
        drive(0, 0, 0, 1, 0);
        checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== 8'h77) begin errors++; $display("FAIL indep_vc1 got=%b/%h exp=1/77", o_rd_valid, o_rd_data); end
        checks++; if (o_wr_ready !== 2'b10 || o_vc_nonempty !== 2'b11) begin errors++; $display("FAIL indep_flags got=%b/%b exp=10/11", o_wr_ready, o_vc_nonempty); end
        drive(0, 0, 0, 0, 0);
        checks++; if (o_rd_data !== head0) begin errors++; $display("FAIL indep_vc0 got=%h exp=%h", o_rd_data, head0); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, W'($urandom_range(0, 255)), 0, 0);
            checks++; if (o_credit_valid !== exp_cv) begin errors++; $display("FAIL wrap_credit_push i=%0d got=%b exp=%b", i, o_credit_valid, exp_cv); end
            tick();
            drive(0, 0, 0, 0, 1);
            checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== mq[0][0]) begin errors++; $display("FAIL wrap_data i=%0d got=%b/%h exp=1/%h", i, o_rd_valid, o_rd_data, mq[0][0]); end
            checks++; if (o_credit_valid !== 1'b0) begin errors++; $display("FAIL wrap_spurious i=%0d got=%b exp=0", i, o_credit_valid); end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        checks++; if (o_credit_valid !== 1'b1 || o_credit_vc !== 1'b0) begin errors++; $display("FAIL wrap_last_credit got=%b/%b exp=1/0", o_credit_valid, o_credit_vc); end
    endtask

    task automatic test_random();
        logic [VW-1:0] rvc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rvc = VW'($urandom_range(0, NV - 1));
            drive(1'($urandom_range(0, 99) < 60), VW'($urandom_range(0, NV - 1)), W'($urandom),
                  rvc, 1'($urandom_range(0, 99) < 45));
            checks++;
            if (o_wr_ready !== exp_ready() || o_vc_nonempty !== exp_nonempty() ||
                o_rd_valid !== (mq[rvc].size() > 0) || o_credit_valid !== exp_cv ||
                o_credit_vc !== exp_cvc || o_err_overflow !== exp_ovf ||
                (mq[rvc].size() > 0 && o_rd_data !== mq[rvc][0])) begin
                errors++;
                $display("FAIL random_cycle i=%0d got rdy=%b ne=%b v=%b d=%h cr=%b/%b ovf=%b exp rdy=%b ne=%b cr=%b/%b ovf=%b",
                         i, o_wr_ready, o_vc_nonempty, o_rd_valid, o_rd_data, o_credit_valid, o_credit_vc,
                         o_err_overflow, exp_ready(), exp_nonempty(), exp_cv, exp_cvc, exp_ovf);
            end
`ifdef NOC_VCFIFO_OCC_EN
            checks++; if (o_occupancy !== exp_occ()) begin errors++; $display("FAIL random_occ i=%0d got=%h exp=%h", i, o_occupancy, exp_occ()); end
`endif
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, VW'($urandom_range(0, NV - 1)), W'($urandom), 0, 0);
            tick();
        end
        reset = 1'b1;
        drive(1, 0, 8'h3C, 0, 1);
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        checks++; if (o_vc_nonempty !== 2'b00 || o_rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_empty got=%b/%b exp=00/0", o_vc_nonempty, o_rd_valid); end
        checks++; if (o_wr_ready !== 2'b11) begin errors++; $display("FAIL midrst_ready got=%b exp=11", o_wr_ready); end
        checks++; if (o_credit_valid !== 1'b0 || o_credit_vc !== 1'b0) begin errors++; $display("FAIL midrst_credit got=%b/%b exp=0/0", o_credit_valid, o_credit_vc); end
`ifdef NOC_VCFIFO_OCC_EN
        checks++; if (o_occupancy !== '0) begin errors++; $display("FAIL midrst_occ got=%h exp=0", o_occupancy); end
`endif
        tick();
        drive(0, 0, 0, 1, 1);
        checks++; if (o_credit_valid !== 1'b0 || o_rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_after got=%b/%b exp=0/0", o_credit_valid, o_rd_valid); end
        tick();
    endtask

    initial begin
        reset   = 1'b1;
        exp_cv  = 1'b0;
        exp_cvc = '0;
        exp_ovf = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simul_push_pop();
        test_vc_independence();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
